seg_cursor_mux: RTL and testbench
=================================

// Module: seg_cursor_mux
// PURPOSE
//  Parametrised N-digit 7-segment scanner with an editable cursor. It replaces the fixed 4-digit
//  one-hot select register in the top level. Debounced buttons move a cursor and inc/dec the hex
//  nibble under it. The block time-multiplexes all digits onto one shared segment bus and blinks
//  the cursor digit while editing. It sits between the debouncer array and the io_sel/io_seg pins.
// PARAMETERS
//  DIGITS     4      number of multiplexed digits (2..8)
//  SCAN_DIV   50000  clk cycles each digit is driven before advancing (>=2)
//  BLINK_DIV  12500000 clk cycles per blink half-period (>=2)
//  WRAP       1      1: cursor wraps at ends; 0: cursor saturates at ends
// PORTS
//  clk        in   1            system clock (100 MHz)
//  rst_n      in   1            reset; synchronous, active-low
//  btn_left   in   1            debounced level; cursor toward higher index
//  btn_right  in   1            debounced level; cursor toward lower index
//  btn_home   in   1            debounced level; cursor to index 0
//  btn_up     in   1            debounced level; nibble at cursor +1 (needs edit_en)
//  btn_down   in   1            debounced level; nibble at cursor -1 (needs edit_en)
//  edit_en    in   1            level; enables up/down, blink and cursor dp
//  sel_n      out  DIGITS       active-low one-hot digit enable
//  seg_n      out  7            active-low segments {g,f,e,d,c,b,a}
//  dp_n       out  1            active-low decimal point
//  cursor     out  clog2(DIGITS) current cursor index
//  values     out  4*DIGITS     nibble i at [4i+3:4i]
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - cursor=0, values=0, scan_idx=0, scan_cnt=0, blink_cnt=0, blink_phase=0.
//   - sel_n, seg_n and dp_n are all 1s.
//   - Edge-history regs load the current button levels, so a button held through reset is not an edge.
//  Edge detect: edge_x = btn_x & ~prev_x; prev regs update every cycle.
//  Commands (one per cycle):
//   - Priority: left > right > home > up > down. Lower-priority simultaneous edges are discarded.
//   - Command takes effect on the edge cycle's clock. cursor/values update 1 cycle after the
//     button rises.
//  Cursor rules:
//   - left at DIGITS-1 -> 0 if WRAP, else unchanged.
//   - right at 0 -> DIGITS-1 if WRAP, else unchanged.
//  Value rules:
//   - up/down act modulo 16 (F+1=0, 0-1=F).
//   - Ignored when edit_en=0. The edge is still consumed and is not retried.
//  Scan:
//   - scan_cnt counts 0..SCAN_DIV-1. At terminal count it clears and scan_idx=(scan_idx+1)%DIGITS.
//   - sel_n, seg_n and dp_n are registered from scan_idx/values, 1 cycle latency.
//   - sel_n = ~(1<<scan_idx).
//  Decode: hex 0-F standard; b,d lowercase. seg_n = ~pattern.
//  Blink:
//   - blink_cnt counts 0..BLINK_DIV-1 and toggles blink_phase at terminal count.
//   - Counter runs always.
//  Cursor display (edit_en=1):
//   - Digit with scan_idx==cursor shows dp_n=0.
//   - Its seg_n=7'h7F while blink_phase=1.
//  edit_en=0: dp_n=1 and no blanking.
//  Mid-scan edits: a value change shows on the next output register update (<=1 cycle).
//  Reset mid-operation overrides every command and scan state in the same cycle.
// TESTING (DIGITS=4, SCAN_DIV=4, BLINK_DIV=8, WRAP=1 unless noted)
//  1) Release reset, hold all buttons 0 for 20 cycles -> sel_n cycles E,D,B,7 at 4 cycles each;
//     seg_n=7'h40 ('0'); cursor=0.
//  2) Hold btn_left through reset, then release reset -> cursor stays 0.
//     Pulse left 5x -> cursor 1,2,3,0,1.
//     Repeat with WRAP=0: 1,2,3,3,3.
//  3) Press left and up in the same cycle with edit_en=1 -> cursor+1; values unchanged.
//  4) edit_en=1, cursor=2, down x1 -> values[11:8]=F.
//     up x2 -> 1.
//     Same with edit_en=0 -> values unchanged.
//  5) edit_en=1, cursor=1 -> when sel_n=D, dp_n=0 and seg_n alternates decode/7F every 8 cycles.
//     edit_en=0 -> dp_n=1, no blank.
//  6) Set values=4'hA at digit 3, then assert rst_n=0 for 1 cycle mid-scan -> next cycle values=0,
//     cursor=0, outputs all 1s. Scan restarts at digit 0.

Source files
------------

// File: rtl/seg_cursor_mux.sv
// N-digit multiplexed 7-segment scanner with a button-driven editing cursor.
// Debounced button edges move the cursor and inc/dec the hex nibble under it.
module seg_cursor_mux #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 12500000,
   parameter bit WRAP      = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        btn_left,
   input  logic                        btn_right,
   input  logic                        btn_home,
   input  logic                        btn_up,
   input  logic                        btn_down,
   input  logic                        edit_en,
   output logic [DIGITS-1:0]           sel_n,
   output logic [6:0]                  seg_n,
   output logic                        dp_n,
   output logic [$clog2(DIGITS)-1:0]   cursor,
   output logic [4*DIGITS-1:0]         values
);

   localparam int CW = $clog2(DIGITS);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_DIV);

   localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);
   localparam logic [SW-1:0] SCAN_TC  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

   localparam logic [2:0] CMD_NONE  = 3'd0;
   localparam logic [2:0] CMD_LEFT  = 3'd1;
   localparam logic [2:0] CMD_RIGHT = 3'd2;
   localparam logic [2:0] CMD_HOME  = 3'd3;
   localparam logic [2:0] CMD_UP    = 3'd4;
   localparam logic [2:0] CMD_DOWN  = 3'd5;

   logic [4:0]             btn_vec;
   logic [4:0]             prev_q;
   logic [4:0]             edges;
   logic [2:0]             cmd;
   logic [CW-1:0]          cursor_nxt;
   logic [4*DIGITS-1:0]    values_nxt;

   logic [CW-1:0]          scan_idx;
   logic [SW-1:0]          scan_cnt;
   logic [BW-1:0]          blink_cnt;
   logic                   blink_phase;

   logic [3:0]             scan_nib;
   logic                   at_cursor;
   logic [DIGITS-1:0]      sel_d;
   logic [6:0]             seg_d;
   logic                   dp_d;

   function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
      logic [6:0] p;
      case (nib)
         4'h0:    p = 7'h3F;
         4'h1:    p = 7'h06;
         4'h2:    p = 7'h5B;
         4'h3:    p = 7'h4F;
         4'h4:    p = 7'h66;
         4'h5:    p = 7'h6D;
         4'h6:    p = 7'h7D;
         4'h7:    p = 7'h07;
         4'h8:    p = 7'h7F;
         4'h9:    p = 7'h6F;
         4'hA:    p = 7'h77;
         4'hB:    p = 7'h7C;
         4'hC:    p = 7'h39;
         4'hD:    p = 7'h5E;
         4'hE:    p = 7'h79;
         default: p = 7'h71;
      endcase
      return p;
   endfunction

   assign btn_vec = {btn_left, btn_right, btn_home, btn_up, btn_down};
   assign edges   = btn_vec & ~prev_q;

   // Only the highest-priority edge of a cycle survives; the rest are dropped, not queued.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      cmd = CMD_NONE;
      if (edges[4])      cmd = CMD_LEFT;
      else if (edges[3]) cmd = CMD_RIGHT;
      else if (edges[2]) cmd = CMD_HOME;
      else if (edges[1]) cmd = CMD_UP;
      else if (edges[0]) cmd = CMD_DOWN;
   end

   always_comb begin
      cursor_nxt = cursor;
      values_nxt = values;
      case (cmd)
         CMD_LEFT: begin
            if (cursor == LAST_IDX) cursor_nxt = WRAP ? '0 : cursor;
            else                    cursor_nxt = cursor + 1'b1;
         end
         CMD_RIGHT: begin
            if (cursor == '0) cursor_nxt = WRAP ? LAST_IDX : cursor;
            else              cursor_nxt = cursor - 1'b1;
         end
         CMD_HOME: cursor_nxt = '0;
         CMD_UP, CMD_DOWN: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (edit_en && CW'(i) == cursor) begin
                  values_nxt[4*i +: 4] = (cmd == CMD_UP) ? values[4*i +: 4] + 4'd1
                                                         : values[4*i +: 4] - 4'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         prev_q <= btn_vec;
         cursor <= '0;
         // NOTE: the nibble bank is flops, not RAM, and must read back zero after reset, so it is reset.
         values <= '0;
      end else begin
         prev_q <= btn_vec;
         cursor <= cursor_nxt;
         values <= values_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_idx    <= '0;
         scan_cnt    <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         if (scan_cnt == SCAN_TC) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         if (blink_cnt == BLINK_TC) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      scan_nib = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         if (CW'(i) == scan_idx) scan_nib = values[4*i +: 4];
      end
   end

   // The cursor digit gets the decimal point and blanks during the blink-on half period.
   assign at_cursor = edit_en && (scan_idx == cursor);
   assign sel_d     = ~(DIGITS'(1) << scan_idx);
   assign seg_d     = (at_cursor && blink_phase) ? 7'h7F : ~hex_pattern(scan_nib);
   assign dp_d      = ~at_cursor;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_n <= '1;
         seg_n <= '1;
         dp_n  <= 1'b1;
      end else begin
         sel_n <= sel_d;
         seg_n <= seg_d;
         dp_n  <= dp_d;
      end
   end

endmodule

// File: tb/tb_seg_cursor_mux.sv
// Randomized bench for seg_cursor_mux: a wrapping and a saturating instance
// share stimulus and are compared every cycle against a cycle-count based model.
module tb_seg_cursor_mux;

   localparam int DIGITS    = 4;
   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 8;

   localparam logic [4:0] B_LEFT  = 5'b10000;
   localparam logic [4:0] B_RIGHT = 5'b01000;
   localparam logic [4:0] B_HOME  = 5'b00100;
   localparam logic [4:0] B_UP    = 5'b00010;
   localparam logic [4:0] B_DOWN  = 5'b00001;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clk = 1'b0;
   logic rst_n, btn_left, btn_right, btn_home, btn_up, btn_down, edit_en;

   logic [3:0]  sel_n0, sel_n1;
   logic [6:0]  seg_n0, seg_n1;
   logic        dp_n0, dp_n1;
   logic [1:0]  cursor0, cursor1;
   logic [15:0] values0, values1;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: [0] = wrapping instance, [1] = saturating instance
   int         m_cur [2];
   logic [3:0] m_val [2][4];
   logic [4:0] m_prev;
   int         m_n;

   always #5 clk = ~clk;

   seg_cursor_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .WRAP(1'b1)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .btn_left(btn_left), .btn_right(btn_right), .btn_home(btn_home),
      .btn_up(btn_up), .btn_down(btn_down), .edit_en(edit_en),
      .sel_n(sel_n0), .seg_n(seg_n0), .dp_n(dp_n0), .cursor(cursor0), .values(values0));

   seg_cursor_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .WRAP(1'b0)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .btn_left(btn_left), .btn_right(btn_right), .btn_home(btn_home),
      .btn_up(btn_up), .btn_down(btn_down), .edit_en(edit_en),
      .sel_n(sel_n1), .seg_n(seg_n1), .dp_n(dp_n1), .cursor(cursor1), .values(values1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
   endtask

   function automatic logic [15:0] pack_vals(input int d);
      return {m_val[d][3], m_val[d][2], m_val[d][1], m_val[d][0]};
   endfunction

   // One clock: drive inputs, predict registered outputs from pre-edge state, advance model, compare.
   task automatic step(input logic r, input logic [4:0] b, input logic e);
      logic [3:0] x_sel [2];
      logic [6:0] x_seg [2];
      logic       x_dp  [2];
      logic [4:0] ed;
      int         idx;
      logic       on;
      rst_n = r;
      {btn_left, btn_right, btn_home, btn_up, btn_down} = b;
      edit_en = e;
      idx = (m_n / SCAN_DIV) % DIGITS;
      for (int d = 0; d < 2; d++) begin
         if (!r) begin
            x_sel[d] = 4'hF; x_seg[d] = 7'h7F; x_dp[d] = 1'b1;
         end else begin
            on       = e && (idx == m_cur[d]);
            x_sel[d] = ~(4'b0001 << idx);
            x_seg[d] = (on && ((m_n / BLINK_DIV) % 2 == 1)) ? 7'h7F : ~SEG_TAB[m_val[d][idx]];
            x_dp[d]  = ~on;
         end
      end
      @(posedge clk);
      if (!r) begin
         for (int d = 0; d < 2; d++) begin
            m_cur[d] = 0;
            for (int k = 0; k < 4; k++) m_val[d][k] = 4'h0;
         end
         m_n = 0;
      end else begin
         ed = b & ~m_prev;
         for (int d = 0; d < 2; d++) begin
            if (ed[4])      m_cur[d] = (m_cur[d] == DIGITS-1) ? ((d == 0) ? 0 : DIGITS-1) : m_cur[d] + 1;
            else if (ed[3]) m_cur[d] = (m_cur[d] == 0) ? ((d == 0) ? DIGITS-1 : 0) : m_cur[d] - 1;
            else if (ed[2]) m_cur[d] = 0;
            else if (ed[1]) begin if (e) m_val[d][m_cur[d]] = m_val[d][m_cur[d]] + 4'd1; end
            else if (ed[0]) begin if (e) m_val[d][m_cur[d]] = m_val[d][m_cur[d]] - 4'd1; end
         end
         m_n++;
      end
      m_prev = b;
      #1;
      check("wrap.sel_n",  32'(sel_n0),  32'(x_sel[0]));
      check("wrap.seg_n",  32'(seg_n0),  32'(x_seg[0]));
      check("wrap.dp_n",   32'(dp_n0),   32'(x_dp[0]));
      check("wrap.cursor", 32'(cursor0), 32'(m_cur[0]));
      check("wrap.values", 32'(values0), 32'(pack_vals(0)));
      check("sat.sel_n",   32'(sel_n1),  32'(x_sel[1]));
      check("sat.seg_n",   32'(seg_n1),  32'(x_seg[1]));
      check("sat.dp_n",    32'(dp_n1),   32'(x_dp[1]));
      check("sat.cursor",  32'(cursor1), 32'(m_cur[1]));
      check("sat.values",  32'(values1), 32'(pack_vals(1)));
   endtask

   task automatic pulse(input logic [4:0] b, input logic e);
      step(1'b1, b, e);
      step(1'b1, 5'b0, e);
   endtask

   initial begin
      logic [4:0] rb;
      logic       re;
      m_n = 0;
      m_prev = 5'b0;
      for (int d = 0; d < 2; d++) begin
         m_cur[d] = 0;
         for (int k = 0; k < 4; k++) m_val[d][k] = 4'h0;
      end

      // idle scan after reset
      step(1'b0, 5'b0, 1'b0);
      check("reset.sel_n", 32'(sel_n0), 32'hF);
      for (int i = 0; i < 20; i++) step(1'b1, 5'b0, 1'b0);

      // left held through reset is not an edge; then 5 pulses
      step(1'b0, B_LEFT, 1'b0);
      step(1'b1, B_LEFT, 1'b0);
      check("held_left.cursor", 32'(cursor0), 32'd0);
      step(1'b1, 5'b0, 1'b0);
      for (int i = 0; i < 5; i++) pulse(B_LEFT, 1'b0);
      check("five_left.wrap", 32'(cursor0), 32'd1);
      check("five_left.sat",  32'(cursor1), 32'd3);

      // left and up together: cursor moves, value untouched
      step(1'b1, B_LEFT | B_UP, 1'b1);
      step(1'b1, 5'b0, 1'b1);
      check("left_up.values", 32'(values0), 32'h0);

      // down/up at cursor 2
      pulse(B_HOME, 1'b1);
      pulse(B_LEFT, 1'b1);
      pulse(B_LEFT, 1'b1);
      pulse(B_DOWN, 1'b1);
      check("down.nib2", 32'(values0[11:8]), 32'hF);
      pulse(B_UP, 1'b1);
      pulse(B_UP, 1'b1);
      check("up2.nib2", 32'(values0[11:8]), 32'h1);
      pulse(B_DOWN, 1'b0);
      check("noedit.nib2", 32'(values0[11:8]), 32'h1);

      // blinking cursor at 1, then no blink with edit_en=0
      pulse(B_RIGHT, 1'b1);
      for (int i = 0; i < 40; i++) step(1'b1, 5'b0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b1, 5'b0, 1'b0);

      // digit 3 = A, then reset mid-scan
      pulse(B_HOME, 1'b1);
      pulse(B_RIGHT, 1'b1);
      for (int i = 0; i < 10; i++) pulse(B_UP, 1'b1);
      check("set_a.nib3", 32'(values0[15:12]), 32'hA);
      step(1'b1, 5'b0, 1'b1);
      step(1'b0, B_UP, 1'b1);
      check("midreset.values", 32'(values0), 32'h0);
      check("midreset.cursor", 32'(cursor0), 32'd0);
      check("midreset.seg_n",  32'(seg_n0), 32'h7F);
      step(1'b1, B_UP, 1'b1);
      check("restart.sel_n",   32'(sel_n0), 32'hE);

      // randomized traffic
      re = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         for (int k = 0; k < 5; k++) rb[k] = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) re = ~re;
         step(($urandom_range(0, 199) != 0), rb, re);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
